// File: rtl/apu_frame_sequencer.sv
// Frame sequencer that turns the DIV-APU rate into the 256/128/64 Hz length, sweep and envelope ticks.
// Optional feature macro: APU_FS_DIV_SYNC_EN steps on an external div_event pulse instead of the internal prescaler.
module apu_frame_sequencer #(
    parameter int PRESCALE_W = 14
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       slow_clk_en_i,
    input  logic       apu_power_i,
    input  logic       div_reset_i,
    input  logic       div_event_i,
    output logic       length_tick_o,
    output logic       sweep_tick_o,
    output logic       env_tick_o,
    output logic [2:0] step_o,
    output logic       next_skips_length_o
);

    logic [2:0] step_q, step_d;
    logic       length_q, length_d;
    logic       sweep_q, sweep_d;
    logic       env_q, env_d;
    logic       step_event;

`ifdef APU_FS_DIV_SYNC_EN
    logic unused_inputs;
    assign unused_inputs = slow_clk_en_i ^ div_reset_i;

    assign step_event = apu_power_i & div_event_i;
`else
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  unused_inputs;
    assign unused_inputs = div_event_i;

    // A DIV write beats a coincident all-ones step, so div_reset masks the event.
    assign step_event = apu_power_i & ~div_reset_i & slow_clk_en_i & (&presc_q);

    always_comb begin
        presc_d = presc_q;
        if (!apu_power_i) begin
            presc_d = '0;
        end else if (div_reset_i) begin
            presc_d = '0;
        end else if (slow_clk_en_i) begin
            presc_d = presc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`endif

    // Ticks decode the step about to be executed, then the step index advances.
    always_comb begin
        step_d   = step_q;
        length_d = 1'b0;
        sweep_d  = 1'b0;
        env_d    = 1'b0;
        if (!apu_power_i) begin
            step_d = 3'd0;
        end else if (step_event) begin
            step_d   = step_q + 3'd1;
            length_d = ~step_q[0];
            sweep_d  = (step_q[1:0] == 2'b10);
            env_d    = (step_q == 3'd7);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            step_q   <= 3'd0;
            length_q <= 1'b0;
            sweep_q  <= 1'b0;
            env_q    <= 1'b0;
        end else begin
            step_q   <= step_d;
            length_q <= length_d;
            sweep_q  <= sweep_d;
            env_q    <= env_d;
        end
    end

    assign length_tick_o       = length_q;
    assign sweep_tick_o        = sweep_q;
    assign env_tick_o          = env_q;
    assign step_o              = step_q;
    assign next_skips_length_o = step_q[0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer with PRESCALE_W=2; covers both APU_FS_DIV_SYNC_EN builds.
module tb_apu_frame_sequencer;

    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic       clk;
    logic       resetN;
    logic       slowClkEn;
    logic       apuPower;
    logic       divReset;
    logic       divEvent;
    logic       lengthTick;
    logic       sweepTick;
    logic       envTick;
    logic [2:0] stepO;
    logic       nextSkipsLength;

    typedef struct {
        logic       len;
        logic       swp;
        logic       env;
        logic [2:0] step;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   mStep = 0;
`ifndef APU_FS_DIV_SYNC_EN
    int   mPresc = 0;
`endif

    apu_frame_sequencer #(.PRESCALE_W(PW)) dut (
        .clk_i              (clk),
        .reset_n_i          (resetN),
        .slow_clk_en_i      (slowClkEn),
        .apu_power_i        (apuPower),
        .div_reset_i        (divReset),
        .div_event_i        (divEvent),
        .length_tick_o      (lengthTick),
        .sweep_tick_o       (sweepTick),
        .env_tick_o         (envTick),
        .step_o             (stepO),
        .next_skips_length_o(nextSkipsLength)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference model: one call per clock edge, pushes what the outputs must show after it.
    task automatic modelCycle(input logic pwr, input logic en, input logic divr, input logic dive);
        exp_t e;
        logic fire;
        e    = '{len: 1'b0, swp: 1'b0, env: 1'b0, step: 3'd0};
        fire = 1'b0;
`ifdef APU_FS_DIV_SYNC_EN
        if (!pwr) mStep = 0;
        else if (dive) fire = 1'b1;
`else
        if (!pwr) begin
            mPresc = 0;
            mStep  = 0;
        end else if (divr) begin
            mPresc = 0;
        end else if (en) begin
            if (mPresc == PMAX) fire = 1'b1;
            mPresc = (mPresc == PMAX) ? 0 : mPresc + 1;
        end
`endif
        if (fire) begin
            e.len = (mStep % 2) == 0;
            e.swp = (mStep == 2) || (mStep == 6);
            e.env = (mStep == 7);
            mStep = (mStep == 7) ? 0 : mStep + 1;
        end
        e.step = 3'(mStep);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic pwr, input logic en, input logic divr, input logic dive);
        exp_t e;
        apuPower  = pwr;
        slowClkEn = en;
        divReset  = divr;
        divEvent  = dive;
        modelCycle(pwr, en, divr, dive);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("queue_empty", 0, 1);
        end else begin
            e = expQ.pop_front();
            checkOutput("length_tick", int'(lengthTick), int'(e.len));
            checkOutput("sweep_tick", int'(sweepTick), int'(e.swp));
            checkOutput("env_tick", int'(envTick), int'(e.env));
            checkOutput("step", int'(stepO), int'(e.step));
            checkOutput("next_skips_length", int'(nextSkipsLength), int'(e.step[0]));
        end
    endtask

    task automatic resetDut();
        resetN = 1'b0;
        #1;
        checkOutput("rst_length", int'(lengthTick), 0);
        checkOutput("rst_sweep", int'(sweepTick), 0);
        checkOutput("rst_env", int'(envTick), 0);
        checkOutput("rst_step", int'(stepO), 0);
        checkOutput("rst_nsl", int'(nextSkipsLength), 0);
        mStep = 0;
`ifndef APU_FS_DIV_SYNC_EN
        mPresc = 0;
`endif
        expQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int lenCnt;
        int swpCnt;
        int envCnt;
        int guard;
        int savedStep;
        resetN    = 1'b0;
        slowClkEn = 1'b0;
        apuPower  = 1'b1;
        divReset  = 1'b0;
        divEvent  = 1'b0;
        resetDut();

        // Async reset while a tick is being shown must clear everything before the next edge.
        guard = 0;
        do begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
            guard++;
        end while (!lengthTick && guard < 40);
        checkOutput("midreset_tick_seen", int'(lengthTick), 1);
        #2;
        resetDut();

`ifndef APU_FS_DIV_SYNC_EN
        // 32 cycles with the enable held high from reset.
        lenCnt = 0; swpCnt = 0; envCnt = 0;
        for (int c = 1; c <= 32; c++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            lenCnt += int'(lengthTick);
            swpCnt += int'(sweepTick);
            envCnt += int'(envTick);
            if (c == 4)  checkOutput("c4_length", int'(lengthTick), 1);
            if (c == 12) checkOutput("c12_sweep", int'(sweepTick), 1);
            if (c == 32) checkOutput("c32_env", int'(envTick), 1);
            if (c == 32) checkOutput("c32_step_wrap", int'(stepO), 0);
        end
        checkOutput("run32_length_count", lenCnt, 4);
        checkOutput("run32_sweep_count", swpCnt, 2);
        checkOutput("run32_env_count", envCnt, 1);

        // Power drop in the cycle that would register the step-4 length tick.
        guard = 0;
        while (!(mStep == 4 && mPresc == PMAX) && guard < 64) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        checkOutput("pwr_reach_guard", int'(guard < 64), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("pwr_drop_step", int'(stepO), 0);
        checkOutput("pwr_drop_length", int'(lengthTick), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("repower_length", int'(lengthTick), 1);
        checkOutput("repower_sweep", int'(sweepTick), 0);
        checkOutput("repower_env", int'(envTick), 0);
        checkOutput("repower_step", int'(stepO), 1);

        // div_reset colliding with an all-ones prescaler.
        guard = 0;
        while (mPresc != PMAX && guard < 8) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            guard++;
        end
        savedStep = mStep;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("divrst_no_length", int'(lengthTick), 0);
        checkOutput("divrst_step_held", int'(stepO), savedStep);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("divrst_step_3en", int'(stepO), savedStep);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("divrst_step_4en", int'(stepO), (savedStep + 1) % 8);

        // Enable only every third cycle; div_event toggles and must be ignored.
        for (int i = 0; i < 72; i++) begin
            applyStimulus(1'b1, (i % 3) == 0, 1'b0, 1'($urandom_range(1)));
        end
`else
        // Eight div_event pulses with a random enable and div_reset that must not matter.
        lenCnt = 0; swpCnt = 0; envCnt = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), (i % 2) == 0);
            lenCnt += int'(lengthTick);
            swpCnt += int'(sweepTick);
            envCnt += int'(envTick);
        end
        checkOutput("sync_length_count", lenCnt, 4);
        checkOutput("sync_sweep_count", swpCnt, 2);
        checkOutput("sync_env_count", envCnt, 1);
        checkOutput("sync_step_wrap", int'(stepO), 0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("sync_pwr_step", int'(stepO), 0);
        checkOutput("sync_pwr_length", int'(lengthTick), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("sync_repower_length", int'(lengthTick), 1);
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
